// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream frame generator.
// Accepts a frame-length command and emits one frame of exactly that many
// bytes (or words when KEEP_ENABLE=0). Byte lane j of a beat carries
// (byte_idx + j) mod 256, so the payload is an incrementing byte pattern
// that restarts at 0 for every frame.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_len/_valid/_ready length command handshake (ready decoded from state)
//   m_axis_*            master stream (tdata, tkeep, tvalid, tready, tlast)
//   busy                frame in progress
//   frame_done          1-cycle pulse after the last beat transfers
//   err_zero_len        1-cycle pulse after a zero-length command is accepted

// Per-lane beat builder: byte enable and byte value for one lane.
module axis_frame_gen_lane #(
  parameter int LANE        = 0,
  parameter int LEN_WIDTH   = 16,
  parameter int KEEP_ENABLE = 1
) (
  input  logic [7:0]           i_idx,
  input  logic [LEN_WIDTH-1:0] i_rem,
  input  logic                 i_last,
  output logic                 o_keep,
  output logic [7:0]           o_byte
);
  // On the last beat only the low rem lanes are enabled.
  assign o_keep = (KEEP_ENABLE == 0) || !i_last || (32'(i_rem) > $unsigned(LANE));
  // Without tkeep the whole word repeats the word index.
  assign o_byte = !o_keep          ? 8'h00 :
                  (KEEP_ENABLE != 0) ? i_idx + 8'(LANE) : i_idx;
endmodule

module axis_frame_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic                  s_len_valid,
  output logic                  s_len_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_zero_len
);
  // Units consumed per beat: bytes with tkeep, one word without.
  localparam int                   STEP_I = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 1;
  localparam logic [LEN_WIDTH-1:0] STEP   = LEN_WIDTH'(STEP_I);
  localparam logic [7:0]           STEP_B = 8'(STEP_I);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [7:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tvalid, r_tlast, r_busy, r_frame_done, r_err_zero_len;

  // Next-beat descriptor: either the first beat of a new command or the
  // beat after the current one. Built combinationally so the beat lands in
  // the output registers with no bubble.
  logic                  w_load;
  logic [LEN_WIDTH-1:0]  w_nrem;
  logic [7:0]            w_nidx;
  logic                  w_nlast;
  logic [KEEP_WIDTH-1:0] w_nkeep;
  logic [DATA_WIDTH-1:0] w_ndata;

  assign w_load  = (r_state == IDLE);
  assign w_nrem  = w_load ? s_len : r_rem - STEP;
  assign w_nidx  = w_load ? 8'h00 : r_idx + STEP_B;
  assign w_nlast = (w_nrem <= STEP);

  for (genvar j = 0; j < KEEP_WIDTH; j++) begin : g_lane
    axis_frame_gen_lane #(
      .LANE(j), .LEN_WIDTH(LEN_WIDTH), .KEEP_ENABLE(KEEP_ENABLE)
    ) u_lane (
      .i_idx (w_nidx),
      .i_rem (w_nrem),
      .i_last(w_nlast),
      .o_keep(w_nkeep[j]),
      .o_byte(w_ndata[j*8 +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rem          <= '0;
      r_idx          <= '0;
      r_tdata        <= '0;
      r_tkeep        <= '0;
      r_tvalid       <= 1'b0;
      r_tlast        <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_zero_len <= 1'b0;
    end else begin
      r_frame_done   <= 1'b0;
      r_err_zero_len <= 1'b0;
      case (r_state)
        IDLE: begin
          if (s_len_valid) begin
            if (s_len == '0) begin
              r_err_zero_len <= 1'b1;
            end else begin
              r_state  <= SEND;
              r_rem    <= w_nrem;
              r_idx    <= w_nidx;
              r_tdata  <= w_ndata;
              r_tkeep  <= w_nkeep;
              r_tlast  <= w_nlast;
              r_tvalid <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end
        SEND: begin
          // Beat registers only move on a transfer, which keeps them
          // stable across stalls.
          if (m_axis_tready) begin
            if (r_tlast) begin
              r_state      <= IDLE;
              r_tvalid     <= 1'b0;
              r_tlast      <= 1'b0;
              r_tkeep      <= '0;
              r_tdata      <= '0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_rem   <= w_nrem;
              r_idx   <= w_nidx;
              r_tdata <= w_ndata;
              r_tkeep <= w_nkeep;
              r_tlast <= w_nlast;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_len_ready   = (r_state == IDLE);
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign err_zero_len  = r_err_zero_len;
endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_len = '0;
  logic        s_len_valid = 1'b0;
  logic        s_len_ready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        busy, frame_done, err_zero_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_frame_gen #(.DATA_WIDTH(64), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_len(s_len), .s_len_valid(s_len_valid), .s_len_ready(s_len_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .frame_done(frame_done),
    .err_zero_len(err_zero_len)
  );

  // {ready, busy, tvalid, tlast, frame_done, err_zero_len, tkeep, tdata}
  wire [77:0] w_obs = {s_len_ready, busy, m_axis_tvalid, m_axis_tlast,
                       frame_done, err_zero_len, m_axis_tkeep, m_axis_tdata};

  // Frame-length monitor: sums enabled bytes per frame, latches at tlast.
  int mon_acc, mon_len, mon_frames;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_acc <= 0; mon_len <= 0; mon_frames <= 0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tlast) begin
        mon_len    <= mon_acc + $countones(m_axis_tkeep);
        mon_acc    <= 0;
        mon_frames <= mon_frames + 1;
      end else begin
        mon_acc <= mon_acc + $countones(m_axis_tkeep);
      end
    end
  end

  // Issue one command; returns on the negedge where the first beat shows.
  task automatic send_cmd(input logic [15:0] len);
    @(negedge clk);
    s_len = len; s_len_valid = 1'b1;
    @(negedge clk);
    s_len_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_asserted: tvalid=%b busy=%b exp 0/0", m_axis_tvalid, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b100000, 8'h00, 64'h0}) begin
      fails++; $display("FAIL reset_state: got %h exp %h", w_obs, {6'b100000, 8'h00, 64'h0});
    end
  endtask

  task automatic test_len16();
    m_axis_tready = 1'b1;
    send_cmd(16);
    tests++;
    if (w_obs !== {6'b011000, 8'hFF, 64'h0706050403020100}) begin
      fails++; $display("FAIL len16_beat1: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b011100, 8'hFF, 64'h0F0E0D0C0B0A0908}) begin
      fails++; $display("FAIL len16_beat2: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b100010, 8'h00, 64'h0} || mon_len != 16) begin
      fails++; $display("FAIL len16_done: got %h mon=%0d exp mon=16", w_obs, mon_len);
    end
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b0) begin
      fails++; $display("FAIL len16_done_pulse: frame_done=%b exp 0", frame_done);
    end
  endtask

  task automatic test_len13();
    send_cmd(13);
    tests++;
    if (w_obs !== {6'b011000, 8'hFF, 64'h0706050403020100}) begin
      fails++; $display("FAIL len13_beat1: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b011100, 8'h1F, 64'h0000000C0B0A0908}) begin
      fails++; $display("FAIL len13_beat2: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b1 || mon_len != 13) begin
      fails++; $display("FAIL len13_mon: fd=%b mon=%0d exp 1/13", frame_done, mon_len);
    end
  endtask

  task automatic test_len1_zero();
    send_cmd(1);
    tests++;
    if (w_obs !== {6'b011100, 8'h01, 64'h0}) begin
      fails++; $display("FAIL len1_beat: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b100010, 8'h00, 64'h0}) begin
      fails++; $display("FAIL len1_done: got %h", w_obs);
    end
    send_cmd(0);
    tests++;
    if (w_obs !== {6'b100001, 8'h00, 64'h0}) begin
      fails++; $display("FAIL zero_len_err: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b100000, 8'h00, 64'h0}) begin
      fails++; $display("FAIL zero_len_quiet: got %h", w_obs);
    end
  endtask

  task automatic test_stall_300();
    int          b = 0;
    logic        stalled = 1'b0;
    logic [72:0] prev = '0;
    logic [72:0] cur;
    logic [7:0]  ek;
    logic [63:0] ed;
    int          stall_fails = 0;
    send_cmd(300);
    for (int cyc = 0; cyc < 3000 && b < 38; cyc++) begin
      cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      ek  = (b == 37) ? 8'h0F : 8'hFF;
      for (int j = 0; j < 8; j++) ed[j*8 +: 8] = ek[j] ? 8'((b*8 + j) % 256) : 8'h00;
      tests++;
      if (m_axis_tvalid !== 1'b1 || cur !== {(b == 37), ek, ed}) begin
        fails++; $display("FAIL len300_beat%0d: v=%b got %h exp %h", b, m_axis_tvalid, cur, {(b == 37), ek, ed});
      end
      if (stalled) begin
        tests++;
        if (cur !== prev) begin
          fails++; stall_fails++;
          if (stall_fails < 4) $display("FAIL len300_stall_hold: got %h exp %h", cur, prev);
        end
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      stalled = !m_axis_tready;
      prev = cur;
      if (m_axis_tready) b++;
      @(negedge clk);
    end
    tests++;
    if (b != 38) begin
      fails++; $display("FAIL len300_timeout: beats=%0d exp 38", b);
    end
    tests++;
    if (m_axis_tvalid !== 1'b0 || frame_done !== 1'b1 || mon_len != 300) begin
      fails++; $display("FAIL len300_end: v=%b fd=%b mon=%0d exp 0/1/300", m_axis_tvalid, frame_done, mon_len);
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    s_len = 8; s_len_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b011100, 8'hFF, 64'h0706050403020100}) begin
      fails++; $display("FAIL b2b_a_beat: got %h", w_obs);
    end
    s_len = 9;
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b100010, 8'h00, 64'h0}) begin
      fails++; $display("FAIL b2b_gap: got %h", w_obs);
    end
    @(negedge clk);
    s_len_valid = 1'b0;
    tests++;
    if (w_obs !== {6'b011000, 8'hFF, 64'h0706050403020100} || mon_len != 8) begin
      fails++; $display("FAIL b2b_b_beat1: got %h mon=%0d exp 8", w_obs, mon_len);
    end
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b011100, 8'h01, 64'h08}) begin
      fails++; $display("FAIL b2b_b_beat2: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b1 || mon_len != 9) begin
      fails++; $display("FAIL b2b_b_mon: fd=%b mon=%0d exp 1/9", frame_done, mon_len);
    end
  endtask

  task automatic test_reset_mid();
    int frames0;
    send_cmd(64);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b011000, 8'hFF, 64'h1716151413121110}) begin
      fails++; $display("FAIL rstmid_beat3: got %h", w_obs);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tlast !== 1'b0) begin
      fails++; $display("FAIL rstmid_clear: v=%b busy=%b last=%b exp 0/0/0", m_axis_tvalid, busy, m_axis_tlast);
    end
    frames0 = mon_frames;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (w_obs !== {6'b100000, 8'h00, 64'h0}) begin
      fails++; $display("FAIL rstmid_idle: got %h", w_obs);
    end
    send_cmd(8);
    tests++;
    if (w_obs !== {6'b011100, 8'hFF, 64'h0706050403020100}) begin
      fails++; $display("FAIL rstmid_new_beat: got %h", w_obs);
    end
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b1 || mon_len != 8 || mon_frames != frames0 + 1) begin
      fails++; $display("FAIL rstmid_new_mon: fd=%b mon=%0d frames=%0d exp 1/8/%0d", frame_done, mon_len, mon_frames, frames0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_len16();
    test_len13();
    test_len1_zero();
    test_stall_300();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
